// File: rtl/edge_request_arbiter.sv
// Rising-edge request capture with round-robin one-hot issue over valid/ready.
// Feeds the 8-to-3 encoder, so every valid out_onehot carries exactly one bit.
module edge_request_arbiter #(
    parameter int N     = 8,
    parameter int PTR_W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_in,
    output logic [N-1:0] out_onehot,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] pending,
    output logic         overflow,
    input  logic         clr_ovf
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       req_prev_q;
    logic [N-1:0]       pending_q, pending_d;
    logic [N-1:0]       onehot_q, onehot_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               ovf_q, ovf_d;

    logic [N-1:0]       rise, acc_mask, cand, sel;
    logic               accept, found;
    logic [PTR_W-1:0]   gnt_idx, gnt_next;

    assign rise     = req_in & ~req_prev_q;
    assign accept   = (state_q == OFFER) && out_ready;
    assign acc_mask = accept ? onehot_q : '0;
    // The bit being accepted this edge is no longer a candidate, nor a pending
    // event for overflow purposes.
    assign cand     = pending_q & ~acc_mask;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = (int'(ptr_q) + i) % N;
            if (!found && cand[j]) begin
                sel[j] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot_q[i]) gnt_idx = PTR_W'(i);
        end
        gnt_next = (gnt_idx == PTR_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_comb begin
        pending_d = cand | rise;
        ovf_d     = ovf_q;
        if (clr_ovf) ovf_d = 1'b0;
        if ((rise & cand) != '0) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_prev_q <= '0;
            pending_q  <= '0;
            onehot_q   <= '0;
            ptr_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_prev_q <= req_in;
            pending_q  <= pending_d;
            onehot_q   <= onehot_d;
            ptr_q      <= ptr_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        onehot_d = onehot_q;
        ptr_d    = ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    onehot_d = sel;
                    state_d  = OFFER;
                end
            end
            OFFER: begin
                if (accept) begin
                    ptr_d = gnt_next;
                    if (found) begin
                        onehot_d = sel;
                    end else begin
                        onehot_d = '0;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                onehot_d = '0;
                state_d  = IDLE;
            end
        endcase
    end

    always_comb begin
        out_valid  = (state_q == OFFER);
        out_onehot = onehot_q;
        pending    = pending_q;
        overflow   = ovf_q;
    end

endmodule

// File: tb/tb_edge_request_arbiter.sv
// Bench for edge_request_arbiter: directed scenarios plus random traffic,
// all compared against a cycle-level behavioural model of the arbiter rules.
module tb_edge_request_arbiter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n, out_ready, clr_ovf, out_valid, overflow;
    logic [N-1:0] req_in, out_onehot, pending;

    int vectors = 0;
    int errors  = 0;

    // Behavioural model: pending events, the index being offered (-1 none).
    logic [N-1:0] m_pend, m_prev;
    int           m_off, m_ptr;
    logic         m_ovf;

    edge_request_arbiter #(.N(N), .PTR_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .req_in(req_in), .out_onehot(out_onehot),
        .out_valid(out_valid), .out_ready(out_ready), .pending(pending),
        .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pend = '0;
        m_prev = '0;
        m_off  = -1;
        m_ptr  = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_step();
        logic         acc;
        logic [N-1:0] keep, rise;
        int           pick;
        acc  = (m_off >= 0) && out_ready;
        keep = m_pend;
        if (acc) keep[m_off] = 1'b0;
        rise = req_in & ~m_prev;
        pick = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (pick < 0 && keep[j]) pick = j;
        end
        if (clr_ovf) m_ovf = 1'b0;
        if ((rise & keep) != '0) m_ovf = 1'b1;
        if (m_off < 0) m_off = pick;
        else if (acc) begin
            m_ptr = (m_off + 1) % N;
            m_off = pick;
        end
        m_pend = keep | rise;
        m_prev = req_in;
    endtask

    function automatic logic [2*N+1:0] exp_vec();
        logic [N-1:0] oh;
        oh = '0;
        if (m_off >= 0) oh[m_off] = 1'b1;
        return {(m_off >= 0), oh, m_pend, m_ovf};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_in = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        #12;
        vectors += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        if (out_onehot !== 8'h00) begin errors++; $display("FAIL reset_onehot got %h want 00", out_onehot); end
        if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending got %h want 00", pending); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++;
            if ({out_valid, out_onehot, pending, overflow} !== exp_vec() ||
                {out_valid, out_onehot, pending, overflow} !== 18'h0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d got %h want 0", c, {out_valid, out_onehot, pending, overflow});
            end
        end
    endtask

    task automatic test_single();
        logic [2*N+1:0] exp_tab [3];
        exp_tab = '{{1'b0, 8'h00, 8'h80, 1'b0}, {1'b1, 8'h80, 8'h80, 1'b0}, {1'b0, 8'h00, 8'h00, 1'b0}};
        out_ready = 1'b1;
        req_in = 8'h80;
        for (int c = 0; c < 3; c++) begin
            tick();
            req_in = 8'h00;
            vectors++;
            if ({out_valid, out_onehot, pending, overflow} !== exp_tab[c] ||
                exp_vec() !== exp_tab[c]) begin
                errors++;
                $display("FAIL single cyc%0d got %h want %h", c, {out_valid, out_onehot, pending, overflow}, exp_tab[c]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_oh [4];
        exp_oh = '{8'h02, 8'h04, 8'h20, 8'h00};
        out_ready = 1'b1;
        req_in = 8'h26;
        tick();
        vectors++;
        if (pending !== 8'h26 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_capture got pend %h valid %b want 26 0", pending, out_valid);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            vectors++;
            if (out_onehot !== exp_oh[c] || out_valid !== (exp_oh[c] != 0) ||
                {out_valid, out_onehot, pending, overflow} !== exp_vec()) begin
                errors++;
                $display("FAIL rr_grant%0d got %h valid %b want %h", c, out_onehot, out_valid, exp_oh[c]);
            end
        end
        req_in = 8'h00;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        req_in = 8'h40;
        tick();
        for (int c = 0; c < 5; c++) begin
            req_in = (c == 1) ? 8'h00 : 8'h40;
            tick();
            vectors++;
            if (out_onehot !== 8'h40 || out_valid !== 1'b1 ||
                {out_valid, out_onehot, pending, overflow} !== exp_vec()) begin
                errors++;
                $display("FAIL bp_hold cyc%0d got %h valid %b want 40 1", c, out_onehot, out_valid);
            end
        end
        vectors++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow got %b want 1", overflow); end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        vectors++;
        if (overflow !== 1'b0 || out_onehot !== 8'h40) begin
            errors++;
            $display("FAIL bp_clr got ovf %b oh %h want 0 40", overflow, out_onehot);
        end
        out_ready = 1'b1;
        tick();
        req_in = 8'h00;
        tick();
        vectors++;
        if ({out_valid, out_onehot, pending, overflow} !== 18'h0) begin
            errors++;
            $display("FAIL bp_drain got %h want 0", {out_valid, out_onehot, pending, overflow});
        end
    endtask

    task automatic test_same_cycle();
        out_ready = 1'b0;
        req_in = 8'h02;
        tick();
        req_in = 8'h00;
        tick();
        req_in = 8'h02;
        out_ready = 1'b1;
        tick();
        vectors++;
        if ({out_valid, out_onehot, pending, overflow} !== {1'b0, 8'h00, 8'h02, 1'b0} ||
            exp_vec() !== {1'b0, 8'h00, 8'h02, 1'b0}) begin
            errors++;
            $display("FAIL same_accept got %h want %h", {out_valid, out_onehot, pending, overflow}, {1'b0, 8'h00, 8'h02, 1'b0});
        end
        tick();
        vectors++;
        if ({out_valid, out_onehot, pending, overflow} !== {1'b1, 8'h02, 8'h02, 1'b0}) begin
            errors++;
            $display("FAIL same_regrant got %h want %h", {out_valid, out_onehot, pending, overflow}, {1'b1, 8'h02, 8'h02, 1'b0});
        end
        req_in = 8'h00;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] exp_oh [4];
        exp_oh = '{8'h00, 8'h10, 8'h20, 8'h00};
        out_ready = 1'b0;
        req_in = 8'h30;
        tick();
        tick();
        vectors++;
        if (out_valid !== 1'b1 || pending !== 8'h30) begin
            errors++;
            $display("FAIL mid_setup got valid %b pend %h want 1 30", out_valid, pending);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, out_onehot, pending, overflow} !== 18'h0) begin
            errors++;
            $display("FAIL mid_async_clear got %h want 0", {out_valid, out_onehot, pending, overflow});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            vectors++;
            if (out_onehot !== exp_oh[c] || overflow !== 1'b0 ||
                {out_valid, out_onehot, pending, overflow} !== exp_vec()) begin
                errors++;
                $display("FAIL mid_regrant%0d got %h want %h", c, out_onehot, exp_oh[c]);
            end
        end
        req_in = 8'h00;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            req_in    = req_in ^ 8'($urandom & $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            clr_ovf   = ($urandom_range(0, 15) == 0);
            tick();
            vectors++;
            if ({out_valid, out_onehot, pending, overflow} !== exp_vec() ||
                !$onehot0(out_onehot) || (out_valid && (out_onehot & pending) == '0)) begin
                errors++;
                $display("FAIL random cyc%0d got %h want %h", c, {out_valid, out_onehot, pending, overflow}, exp_vec());
            end
        end
        clr_ovf = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/edge_request_arbiter.md
Name: edge_request_arbiter

Overview:
- Upstream stage of the 8-to-3 encoder.
- Samples N asynchronous-free, synchronous request lines and detects rising edges.
- Holds each event as a pending bit, and issues exactly one pending request at a time as a one-hot vector over a valid/ready handshake, using round-robin priority.
- The downstream encoder converts the one-hot grant into a binary code, so every vector it receives is guaranteed to be one-hot.

Parameters:
- N, 8, number of request lines and width of the one-hot output; N >= 2.
- PTR_W, 3, width of the round-robin pointer; must equal clog2(N).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_in  input  N  request lines, synchronous to clk; an event is a 0->1 transition.
- out_onehot  output  N  granted request, one-hot; all-zero when out_valid=0.
- out_valid  output  1  out_onehot holds a valid grant.
- out_ready  input  1  downstream accepts the grant this cycle.
- pending  output  N  registered set of captured, not-yet-accepted events.
- overflow  output  1  sticky: an event arrived on a line whose previous event was still pending.
- clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, sync release): req_prev=0, pending=0, out_onehot=0, out_valid=0, ptr=0, overflow=0, state=IDLE.
- Edge detect: rise = req_in & ~req_prev; req_prev <= req_in every cycle. A line already high at the first clock after reset counts as one rise.
- accept = out_valid & out_ready. acc_mask = out_onehot when accept, else 0.
- Pending update: pending <= (pending & ~acc_mask) | rise.
  - Rise and accept on the same bit in the same cycle: the bit stays set. This is a new event, not overflow.
- Overflow: set when any bit has rise=1 and is pending & ~acc_mask. The offered-but-not-accepted bit counts as pending.
  - clr_ovf=1 clears it.
  - clr_ovf and a new overflow in the same cycle: set wins.
- Selection: cand = pending & ~acc_mask, using registered pending only. Rises are visible one cycle later.
  - Pick the first set bit of cand searching from index ptr upward, wrapping N-1 -> 0.
- State machine:
  - IDLE: out_valid=0. If cand != 0, load out_onehot with the selected bit, set out_valid=1, go to OFFER.
  - OFFER: out_onehot and out_valid must hold stable until accept.
    - On accept, ptr <= (granted index + 1) mod N.
    - If cand != 0, load the next selection in the same edge and stay in OFFER. This gives back-to-back grants, one per cycle with out_ready held at 1.
    - Otherwise clear out_onehot, set out_valid=0, and go to IDLE.
- Latency: rise sampled at edge E0 sets pending at E0; out_valid rises at E1 when IDLE.
- Stability: while out_valid=1 and out_ready=0, no change of out_onehot. New rises only accumulate in pending.
- Invariants: out_onehot is zero or one-hot; out_valid=1 implies out_onehot is one-hot and its bit is set in pending.
- Reset mid-handshake: all state is cleared immediately. Dropped events are not recovered, and overflow is not set.

Test Plan:
- Reset with req_in=0 -> out_valid=0, out_onehot=8'h00, pending=8'h00, overflow=0. Release; hold 5 cycles -> outputs unchanged.
- Single rise on req_in[7] (8'h80), out_ready=1:
  - pending=8'h80 after E0; out_onehot=8'h80, out_valid=1 at E1; accepted at E2.
  - Then pending=8'h00, out_valid=0, ptr=0.
- req_in 8'h00->8'h26 in one cycle, out_ready=1, ptr=0 -> grants 8'h02, 8'h04, 8'h20 on consecutive cycles, then out_valid=0, ptr=6.
- Backpressure: req_in[6] rise, out_ready=0 for 4 cycles -> out_onehot=8'h40 held stable.
  - Pulse req_in[6] low then high during the stall -> overflow=1.
  - clr_ovf pulse -> overflow=0.
- Same-cycle accept and re-rise on bit 1 -> grant 8'h02 accepted, pending[1] stays 1, second grant 8'h02 follows, overflow=0.
- rst_n asserted mid-handshake (out_valid=1, pending=8'h30) -> outputs clear asynchronously without waiting for clk; after release with req_in held 8'h30 -> grants 8'h10 then 8'h20 (treated as new rises).
